// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampling 8N1 UART receiver.
// Start-bit validation at mid-bit, then one sample per bit period at bit centre.
// Every state change is gated by the oversampling enable tick_os.
module uart_rx_os16 #(
  parameter int OS        = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 tick_os,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int OSW = $clog2(OS);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [OSW-1:0] LIM_HALF = OSW'(OS / 2 - 1);
  localparam logic [OSW-1:0] LIM_FULL = OSW'(OS - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nxt;
  logic [OSW-1:0]       os_cnt, os_cnt_nxt;
  logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
  logic [BCW-1:0]       bit_inc;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt;
  logic                 frame_err_nxt;
  logic                 rx_p0;
  logic                 rx_s;

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  assign bit_inc = bit_cnt + BCW'(1);

  // Next-state, counter and output decode; nothing moves without a tick.
  always_comb begin
    state_nxt     = state;
    os_cnt_nxt    = os_cnt;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    data_nxt      = data;
    valid_nxt     = 1'b0;
    frame_err_nxt = 1'b0;
    if (tick_os) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt  = START;
            os_cnt_nxt = '0;
          end
        end
        START: begin
          if (os_cnt == LIM_HALF) begin
            os_cnt_nxt = '0;
            if (!rx_s) begin
              state_nxt   = DATA;
              bit_cnt_nxt = '0;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              state_nxt = IDLE;
            end
          end else begin
            os_cnt_nxt = os_cnt + OSW'(1);
          end
        end
        DATA: begin
          if (os_cnt == LIM_FULL) begin
            os_cnt_nxt  = '0;
            shift_nxt   = {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt_nxt = bit_inc;
            if (bit_inc == BIT_LAST) begin
              state_nxt = STOP;
            end
          end else begin
            os_cnt_nxt = os_cnt + OSW'(1);
          end
        end
        STOP: begin
          if (os_cnt == LIM_FULL) begin
            os_cnt_nxt = '0;
            state_nxt  = IDLE;
            if (rx_s) begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
            end else begin
              // Bad stop bit: keep the last good byte on data.
              frame_err_nxt = 1'b1;
            end
          end else begin
            os_cnt_nxt = os_cnt + OSW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      os_cnt    <= os_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: directed bench for the oversampling UART receiver.
// tick_os every 4 clk_in cycles, so one bit spans 64 cycles; strobes are
// checked against a scoreboard that also carries the expected strobe cycle.
module tb_uart_rx_os16;

  typedef struct {
    logic       err;
    logic [7:0] d;
    int         at;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       tick_os;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int         pcnt = 0;
  int         n_pass = 0;
  int         n_total = 0;
  int         n_strobes = 0;
  logic [7:0] last_good = 8'h00;
  exp_t       sb[$];
  exp_t       e;

  uart_rx_os16 #(.OS(16), .DATA_BITS(8)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .tick_os   (tick_os),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  // Index of the most recent rising edge; read only at falling edges.
  always @(posedge clk_in) pcnt <= pcnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one cycle; inputs change on the falling edge.
  task automatic cyc();
    @(negedge clk_in);
    tick_os = ((pcnt + 1) % 4 == 0);
  endtask

  // Drive a frame starting now: start bit plus nslots further bit slots
  // (9 = full frame including stop). Pushes the expected strobe if asked.
  task automatic drive_frame(input logic [7:0] d, input logic stop, input int nslots,
                             input bit expect_strobe, output int t0);
    int   k;
    exp_t x;
    rx = 1'b0;
    k  = pcnt;
    t0 = k + 3;
    while (t0 % 4 != 0) t0++;
    if (expect_strobe) begin
      x.err = !stop;
      x.d   = stop ? d : last_good;
      x.at  = t0 + 152 * 4;
      sb.push_back(x);
      if (stop) last_good = d;
    end
    for (int i = 1; i <= nslots; i++) begin
      repeat (64) cyc();
      rx = (i <= 8) ? d[i-1] : stop;
    end
    repeat (64) cyc();
  endtask

  // Strobe monitor: every valid/frame_err pulse must match the scoreboard head.
  always @(negedge clk_in) begin
    if (valid || frame_err) begin
      n_strobes++;
      chk("strobe_exclusive", {31'd0, valid & frame_err}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {31'd0, valid}, {31'd0, ~valid});
      end else begin
        e = sb.pop_front();
        chk("strobe_valid", {31'd0, valid}, {31'd0, ~e.err});
        chk("strobe_frame_err", {31'd0, frame_err}, {31'd0, e.err});
        chk("strobe_data", {24'd0, data}, {24'd0, e.d});
        chk("strobe_cycle", pcnt, e.at);
      end
    end
  end

  initial begin
    int t0;
    int k;
    rst     = 1'b1;
    rx      = 1'b1;
    tick_os = 1'b0;

    // Reset held for 3 cycles with line idle
    repeat (3) begin
      cyc();
      chk("rst_data", {24'd0, data}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1'b0;
    repeat (20) cyc();
    chk("idle_data", {24'd0, data}, 32'd0);
    chk("idle_valid", {31'd0, valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Good frame 0x55
    drive_frame(8'h55, 1'b1, 9, 1'b1, t0);
    repeat (100) cyc();
    chk("after_55_data", {24'd0, data}, 32'h55);
    chk("after_55_busy", {31'd0, busy}, 32'd0);

    // Glitch: line low for 4 ticks only
    rx = 1'b0;
    k  = pcnt;
    t0 = k + 3;
    while (t0 % 4 != 0) t0++;
    for (int m = 1; m <= t0 - k + 40; m++) begin
      cyc();
      if (m == 16) rx = 1'b1;
      if (pcnt == t0 - 1) chk("glitch_busy_pre", {31'd0, busy}, 32'd0);
      if (pcnt == t0) chk("glitch_busy_rise", {31'd0, busy}, 32'd1);
      if (pcnt == t0 + 31) chk("glitch_busy_hold", {31'd0, busy}, 32'd1);
      if (pcnt == t0 + 32) chk("glitch_busy_fall", {31'd0, busy}, 32'd0);
    end
    repeat (100) cyc();

    // Bad stop bit on 0xA3: frame_err only, data keeps 0x55
    drive_frame(8'hA3, 1'b0, 9, 1'b1, t0);
    rx = 1'b1;
    repeat (200) cyc();
    chk("badstop_data", {24'd0, data}, 32'h55);
    chk("badstop_busy", {31'd0, busy}, 32'd0);

    // Back-to-back 0x00 then 0xFF, no idle gap
    drive_frame(8'h00, 1'b1, 9, 1'b1, t0);
    drive_frame(8'hFF, 1'b1, 9, 1'b1, t0);
    repeat (100) cyc();
    chk("b2b_data", {24'd0, data}, 32'hFF);

    // Reset mid-frame, just after data bit 3 was sampled
    drive_frame(8'hC3, 1'b1, 4, 1'b0, t0);
    chk("midframe_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    rx  = 1'b1;
    cyc();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("midrst_data", {24'd0, data}, 32'd0);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (300) cyc();
    chk("postrst_busy", {31'd0, busy}, 32'd0);

    // Frame after the aborted one
    drive_frame(8'h3C, 1'b1, 9, 1'b1, t0);
    repeat (100) cyc();
    chk("final_data", {24'd0, data}, 32'h3C);
    chk("sb_drained", sb.size(), 32'd0);
    chk("strobe_count", n_strobes, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
